// File: rtl/hdmi_pkg.sv
// Shared types and defaults for the HDMI PLL power-up sequencer.
package hdmi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    BACKOFF   = 3'd5,
    FAIL      = 3'd6
  } state_e;

  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT  = 2500;
  localparam int DEF_STABLE_CYCLES = 256;
  localparam int DEF_MAX_RETRIES   = 4;
  localparam int DEF_CNT_W         = 16;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer, clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hdmi_pll_sequencer.sv
// Power-up / lock-recovery sequencer for the HDMI PLL, running on the 25 MHz reference.
// Outputs are registered and decoded from the next state so they move with the state.
module hdmi_pll_sequencer
  import hdmi_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       hdmi_reset,
  output logic       ready,
  output logic       failed,
  output logic [2:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_resetb_q, hdmi_reset_q, ready_q, failed_q;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // next-state, shared counter and retry/loss bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (!enable) begin
      state_d = IDLE;
      retry_d = 3'd0;
    end else if (restart) begin
      state_d = PLL_RST;
      retry_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: state_d = PLL_RST;
        PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
          else                   state_d = PLL_RST;
        end
        WAIT_LOCK: begin
          if (lock_s)                state_d = STABLE;
          else if (cnt_q == TO_LAST) state_d = BACKOFF;
          else                       state_d = WAIT_LOCK;
        end
        STABLE: begin
          // any dropout restarts the consecutive-lock requirement
          if (!lock_s)                state_d = WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = RUN;
          else                        state_d = STABLE;
        end
        RUN: begin
          if (!lock_s) begin
            loss_d  = sat_inc8(loss_q);
            retry_d = 3'd0;
            state_d = PLL_RST;
          end else begin
            state_d = RUN;
          end
        end
        BACKOFF: begin
          retry_d = sat_inc3(retry_q);
          if (int'(retry_d) >= MAX_RETRIES) state_d = FAIL;
          else                              state_d = PLL_RST;
        end
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
    // restart re-enters PLL_RST even from PLL_RST, so it must clear the count too
    if ((state_d != state_q) || (enable && restart)) cnt_d = '0;
    else                                              cnt_d = cnt_q + CNT_W'(1);
  end

  // state, counters and registered output decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      retry_q      <= 3'd0;
      loss_q       <= 8'd0;
      pll_resetb_q <= 1'b0;
      hdmi_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
      hdmi_reset_q <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
      failed_q     <= (state_d == FAIL);
    end
  end

  assign pll_resetb      = pll_resetb_q;
  assign hdmi_reset      = hdmi_reset_q;
  assign ready           = ready_q;
  assign failed          = failed_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_hdmi_pll_sequencer.sv
// Directed bench for hdmi_pll_sequencer: vector table plus hand-written lock-loss,
// glitch, reset/enable and saturation sequences.
module tb_hdmi_pll_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       restart;
  logic       pll_locked;
  logic       pll_resetb;
  logic       hdmi_reset;
  logic       ready;
  logic       failed;
  logic [2:0] retry_count;
  logic [7:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  hdmi_pll_sequencer #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .CNT_W         (16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .restart         (restart),
    .pll_locked      (pll_locked),
    .pll_resetb      (pll_resetb),
    .hdmi_reset      (hdmi_reset),
    .ready           (ready),
    .failed          (failed),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rs;
    logic       lk;
    int         n;
    logic       e_resetb;
    logic       e_hdmi;
    logic       e_rdy;
    logic       e_fail;
    logic [2:0] e_retry;
    logic [7:0] e_loss;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return ready;
      1:       return hdmi_reset;
      2:       return pll_resetb;
      default: return failed;
    endcase
  endfunction

  // returns edges elapsed until the probed output equals val, or -1 on timeout
  task automatic wait_for(input int sel, input logic val, input int max_edges, output int n);
    n = 0;
    while (probe(sel) !== val && n < max_edges) begin
      @(negedge clk);
      n++;
    end
    if (probe(sel) !== val) n = -1;
  endtask

  task automatic lock_dip();
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
  endtask

  initial begin
    int n;
    int low;
    int timeouts;

    //          en    rs    lk    n   resetb hdmi  rdy   fail  retry loss
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 21, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});

    reset_n    = 1'b0;
    enable     = 1'b0;
    restart    = 1'b0;
    pll_locked = 1'b0;
    #30;
    check("rst_resetb", int'(pll_resetb), 0);
    check("rst_hdmi",   int'(hdmi_reset), 1);
    check("rst_ready",  int'(ready), 0);
    check("rst_failed", int'(failed), 0);
    check("rst_retry",  int'(retry_count), 0);
    check("rst_loss",   int'(lock_loss_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // bring-up, timeout to FAIL, restart recovery
    for (int i = 0; i < tbl.size(); i++) begin
      enable     = tbl[i].en;
      restart    = tbl[i].rs;
      pll_locked = tbl[i].lk;
      repeat (tbl[i].n) @(negedge clk);
      check($sformatf("row%0d_resetb", i), int'(pll_resetb), int'(tbl[i].e_resetb));
      check($sformatf("row%0d_hdmi", i),   int'(hdmi_reset), int'(tbl[i].e_hdmi));
      check($sformatf("row%0d_ready", i),  int'(ready),      int'(tbl[i].e_rdy));
      check($sformatf("row%0d_failed", i), int'(failed),     int'(tbl[i].e_fail));
      check($sformatf("row%0d_retry", i),  int'(retry_count), int'(tbl[i].e_retry));
      check($sformatf("row%0d_loss", i),   int'(lock_loss_count), int'(tbl[i].e_loss));
    end
    restart = 1'b0;

    // lock loss in RUN
    enable     = 1'b1;
    pll_locked = 1'b1;
    wait_for(0, 1'b1, 40, n);
    check("ll_reach_run", n, 14);
    lock_dip();
    wait_for(1, 1'b1, 10, n);
    check("ll_hdmi_edges", n + 1, 3);
    check("ll_ready", int'(ready), 0);
    check("ll_count", int'(lock_loss_count), 1);
    check("ll_retry", int'(retry_count), 0);
    low = 0;
    while (pll_resetb == 1'b0 && low < 20) begin
      low++;
      @(negedge clk);
    end
    check("ll_resetb_low", low, 4);
    wait_for(0, 1'b1, 40, n);
    check("ll_rerun", int'(n >= 0 && ready == 1'b1), 1);

    // enable=0 while in RUN
    enable = 1'b0;
    @(negedge clk);
    check("en0_ready",  int'(ready), 0);
    check("en0_hdmi",   int'(hdmi_reset), 1);
    check("en0_resetb", int'(pll_resetb), 0);
    check("en0_loss",   int'(lock_loss_count), 1);

    // single-cycle lock glitch in STABLE at count 5
    pll_locked = 1'b0;
    enable     = 1'b1;
    wait_for(2, 1'b1, 20, n);
    check("gl_wait_lock", int'(n >= 0), 1);
    pll_locked = 1'b1;
    repeat (6) @(negedge clk);
    check("gl_not_run", int'(ready), 0);
    lock_dip();
    wait_for(0, 1'b1, 40, n);
    check("gl_ready_edges", n + 1, 12);

    // async reset in the middle of STABLE
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (7) @(negedge clk);
    check("ar_in_stable", int'(pll_resetb == 1'b1 && ready == 1'b0), 1);
    check("ar_loss_before", int'(lock_loss_count), 1);
    #5 reset_n = 1'b0;
    #1;
    check("ar_resetb", int'(pll_resetb), 0);
    check("ar_hdmi",   int'(hdmi_reset), 1);
    check("ar_ready",  int'(ready), 0);
    check("ar_loss",   int'(lock_loss_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // lock-loss counter saturation
    timeouts = 0;
    for (int k = 0; k < 260; k++) begin
      wait_for(0, 1'b1, 60, n);
      if (n < 0) timeouts++;
      lock_dip();
      wait_for(0, 1'b0, 10, n);
      if (n < 0) timeouts++;
      if (k == 253) check("sat_254", int'(lock_loss_count), 254);
    end
    check("sat_timeouts", timeouts, 0);
    check("sat_loss", int'(lock_loss_count), 255);
    wait_for(0, 1'b1, 60, n);
    check("sat_hold", int'(lock_loss_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
